// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: merges the pipeline W-stage write (port A) with
// results from long-latency units (port B) onto the single GRF write port.
// B results sit in a small FIFO and drain whenever A is idle. If a B entry
// has waited STARVE_MAX cycles, it preempts A for one cycle.
// A per-register busy bitmap tracks issued long-latency ops that have not
// yet written back.
module grf_wb_arbiter #(
   parameter int B_DEPTH    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_we,
   input  logic [4:0]  a_wa,
   input  logic [31:0] a_wd,
   input  logic [31:0] a_pc,
   output logic        a_stall,
   input  logic        b_valid,
   input  logic [4:0]  b_wa,
   input  logic [31:0] b_wd,
   input  logic [31:0] b_pc,
   output logic        b_ready,
   input  logic        b_issue,
   input  logic [4:0]  b_issue_wa,
   output logic [31:0] busy,
   output logic        grf_we,
   output logic [4:0]  grf_wa,
   output logic [31:0] grf_wd,
   output logic [31:0] grf_wpc
);

   localparam int PTR_W = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
   localparam int CNT_W = $clog2(B_DEPTH) + 1;
   localparam int ST_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(B_DEPTH);
   localparam logic [ST_W-1:0]  STARVE_C = ST_W'(STARVE_MAX);

   logic [4:0]       buf_wa [B_DEPTH];
   logic [31:0]      buf_wd [B_DEPTH];
   logic [31:0]      buf_pc [B_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [ST_W-1:0]  starve;
   logic [31:0]      busy_nxt;

   logic       a_valid;
   logic       b_avail;
   logic       sel_a;
   logic       sel_b;
   logic       push;
   logic       pop;
   logic [4:0] head_wa;

   // Request qualification and A/B selection; a write to r0 is no request.
   always_comb begin
      a_valid = reset && a_we && (a_wa != 5'd0);
      b_avail = (count != '0);
      sel_b   = b_avail && (!a_valid || (starve == STARVE_C));
      sel_a   = a_valid && !sel_b;
      b_ready = reset && (count < DEPTH_C);
      push    = b_valid && b_ready;
      pop     = sel_b;
      head_wa = buf_wa[rd_ptr];
      a_stall = a_valid && sel_b;
   end

   // GRF write port mux, zero latency. A head with wa=0 drains without writing.
   always_comb begin
      grf_we  = 1'b0;
      grf_wa  = 5'd0;
      grf_wd  = 32'd0;
      grf_wpc = 32'd0;
      if (sel_b) begin
         grf_we  = (head_wa != 5'd0);
         grf_wa  = head_wa;
         grf_wd  = buf_wd[rd_ptr];
         grf_wpc = buf_pc[rd_ptr];
      end else if (sel_a) begin
         grf_we  = 1'b1;
         grf_wa  = a_wa;
         grf_wd  = a_wd;
         grf_wpc = a_pc;
      end
   end

   // Busy bitmap update: clear on B writeback, set on issue (set wins), r0 never busy.
   always_comb begin
      busy_nxt = busy;
      if (pop && (head_wa != 5'd0))
         busy_nxt[head_wa] = 1'b0;
      if (b_issue && (b_issue_wa != 5'd0))
         busy_nxt[b_issue_wa] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // FIFO storage write on push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < B_DEPTH; i++) begin
            buf_wa[i] <= 5'd0;
            buf_wd[i] <= 32'd0;
            buf_pc[i] <= 32'd0;
         end
      end else if (push) begin
         buf_wa[wr_ptr] <= b_wa;
         buf_wd[wr_ptr] <= b_wd;
         buf_pc[wr_ptr] <= b_pc;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Starvation counter: counts cycles the head waits behind A, saturating.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         starve <= '0;
      else if (!b_avail || pop)
         starve <= '0;
      else if (starve != STARVE_C)
         starve <= starve + ST_W'(1);
   end

   // Busy bitmap register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         busy <= 32'd0;
      else
         busy <= busy_nxt;
   end

endmodule
